// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared definitions for the fetch sequencer.
// Holds control-bus field layout, state encodings, bus-ID constants
// and the control-word pack helper used by the Moore output decode.
package fetch_sequencer_pkg;

  localparam int CTRL_W = 20;

  // Control bus layout, MSB first:
  // {ALU_OPCODE[4:0], MID[4:0], SID[4:0], AMID[1:0], PC_INR, MID_EN, SID_EN}
  localparam int ALU_LSB    = 15;
  localparam int ALU_W      = 5;
  localparam int MID_LSB    = 10;
  localparam int MID_W      = 5;
  localparam int SID_LSB    = 5;
  localparam int SID_W      = 5;
  localparam int AMID_LSB   = 3;
  localparam int AMID_W     = 2;
  localparam int PC_INR_BIT = 2;
  localparam int MID_EN_BIT = 1;
  localparam int SID_EN_BIT = 0;

  // Bus arbitration IDs
  localparam logic [MID_W-1:0]  MID_MEM = 5'd4;
  localparam logic [SID_W-1:0]  SID_IR0 = 5'd0;
  localparam logic [SID_W-1:0]  SID_IR1 = 5'd1;
  localparam logic [AMID_W-1:0] AMID_PC = 2'd0;

  // Sequencer states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_F0   = 3'd1;
  localparam logic [2:0] ST_F1   = 3'd2;
  localparam logic [2:0] ST_F2   = 3'd3;
  localparam logic [2:0] ST_F3   = 3'd4;
  localparam logic [2:0] ST_F4   = 3'd5;
  localparam logic [2:0] ST_EXEC = 3'd6;
  localparam logic [2:0] ST_HALT = 3'd7;

  function automatic logic [CTRL_W-1:0] pack_ctrl(
    input logic [ALU_W-1:0]  alu,
    input logic [MID_W-1:0]  mid,
    input logic [SID_W-1:0]  sid,
    input logic [AMID_W-1:0] amid,
    input logic              pc_inr,
    input logic              mid_en,
    input logic              sid_en
  );
    logic [CTRL_W-1:0] w;
    w = '0;
    w[ALU_LSB +: ALU_W]   = alu;
    w[MID_LSB +: MID_W]   = mid;
    w[SID_LSB +: SID_W]   = sid;
    w[AMID_LSB +: AMID_W] = amid;
    w[PC_INR_BIT]         = pc_inr;
    w[MID_EN_BIT]         = mid_en;
    w[SID_EN_BIT]         = sid_en;
    return w;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: run/decoder/execute-unit inputs and control-bus/status
// outputs of the fetch sequencer. master = sequencer, slave = environment.
// Signals: run, hlt, exec_ctrl, exec_done in; control_bus, exec_start, halted, wdt_err, instr_count out.
interface fetch_sequencer_if #(
  parameter int CTRL_W = 20,
  parameter int CNT_W  = 16
);
  logic              run;
  logic              hlt;
  logic [CTRL_W-1:0] exec_ctrl;
  logic              exec_done;
  logic [CTRL_W-1:0] control_bus;
  logic              exec_start;
  logic              halted;
  logic              wdt_err;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    input  run, hlt, exec_ctrl, exec_done,
    output control_bus, exec_start, halted, wdt_err, instr_count
  );

  modport slave (
    output run, hlt, exec_ctrl, exec_done,
    input  control_bus, exec_start, halted, wdt_err, instr_count
  );
endinterface

// File: rtl/fetch_sequencer_exec_watchdog.sv
// fetch_sequencer_exec_watchdog: counts EXEC cycles lacking exec_done.
// Latency: expired_o is combinational in the last permitted EXEC cycle.
// No backpressure; counter clears whenever EXEC is not active or done arrives.
// Ports: clk_i, rst_i, active_i (in EXEC), done_i (exec_done), expired_o.
module fetch_sequencer_exec_watchdog #(
  parameter int EXEC_TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic done_i,
  output logic expired_o
);

  localparam logic [15:0] LAST = 16'(EXEC_TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  // Outside EXEC the count is held at zero, so every EXEC entry starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || done_i) cnt_d = '0;
    else                     cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // exec_done in the final cycle wins over expiry.
  assign expired_o = active_i && !done_i && (cnt_q == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control-bus master running F0..F4 fetch then handing bus to execute unit.
// Latency: first F0 one cycle after run seen in IDLE; 5 fetch cycles + N EXEC cycles per instruction.
// No backpressure; EXEC waits for exec_done, bounded by the exec watchdog.
// Ports: clk_i, rst_i (async, active-high), bus (fetch_sequencer_if.master).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int EXEC_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fetch_sequencer_if.master bus
);

  logic [2:0]        state_q, state_d;
  logic              first_q, first_d;
  logic              wdt_q, wdt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_bus;
  logic              in_exec;
  logic              wdt_expired;

  assign in_exec = (state_q == ST_EXEC);

  fetch_sequencer_exec_watchdog #(
    .EXEC_TIMEOUT(EXEC_TIMEOUT)
  ) u_wdt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .active_i  (in_exec),
    .done_i    (bus.exec_done),
    .expired_o (wdt_expired)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.run) state_d = ST_F0;
      ST_F0:   state_d = ST_F1;
      ST_F1:   state_d = ST_F2;
      ST_F2:   state_d = ST_F3;
      ST_F3:   state_d = ST_F4;
      ST_F4:   state_d = bus.hlt ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (bus.exec_done)    state_d = ST_F0;
        else if (wdt_expired) state_d = ST_HALT;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // first_q marks the opening EXEC cycle for the exec_start pulse.
  assign first_d = (state_q == ST_F4) && !bus.hlt;
  assign wdt_d   = wdt_q | wdt_expired;
  assign cnt_d   = (in_exec && bus.exec_done) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      wdt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      wdt_q   <= wdt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode of the fetch states; EXEC forwards the execute unit's word.
  always_comb begin
    ctrl_bus = '0;
    unique case (state_q)
      ST_F0:   ctrl_bus = pack_ctrl('0, MID_MEM, SID_IR0, AMID_PC, 1'b0, 1'b1, 1'b0);
      ST_F1:   ctrl_bus = pack_ctrl('0, MID_MEM, SID_IR0, AMID_PC, 1'b1, 1'b1, 1'b1);
      ST_F2:   ctrl_bus = pack_ctrl('0, MID_MEM, SID_IR0, AMID_PC, 1'b0, 1'b1, 1'b0);
      ST_F3:   ctrl_bus = pack_ctrl('0, MID_MEM, SID_IR1, AMID_PC, 1'b1, 1'b1, 1'b1);
      ST_EXEC: ctrl_bus = bus.exec_ctrl;
      default: ctrl_bus = '0;
    endcase
  end

  assign bus.control_bus = ctrl_bus;
  assign bus.exec_start  = in_exec && first_q;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.wdt_err     = wdt_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized instruction-level stimulus with a scoreboard.
// The driver pushes the expected per-cycle outputs; a negedge monitor pops and compares.
module tb_fetch_sequencer;

  localparam int TO = 8;
  localparam int CW = 4;

  typedef struct packed {
    logic [19:0]   bus;
    logic          start;
    logic          halted;
    logic          wdt;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.CTRL_W(20), .CNT_W(CW)) bus_if ();

  fetch_sequencer #(.EXEC_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_count = 0;
  bit   m_wdt = 1'b0;

  // Expected fetch words from the field layout: MID_MEM=4 at [14:10], SID at [9:5],
  // PC_INR bit2, MID_EN bit1, SID_EN bit0.
  logic [19:0] fetch_w [5] = '{20'h01002, 20'h01007, 20'h01002, 20'h01027, 20'h00000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("control_bus", 32'(bus_if.control_bus), 32'(e.bus));
      chk("exec_start",  32'(bus_if.exec_start),  32'(e.start));
      chk("halted",      32'(bus_if.halted),      32'(e.halted));
      chk("wdt_err",     32'(bus_if.wdt_err),     32'(e.wdt));
      chk("instr_count", 32'(bus_if.instr_count), 32'(e.cnt));
    end
  end

  task automatic expect_cyc(input logic [19:0] b, input bit st, input bit h);
    exp_t e;
    e.bus    = b;
    e.start  = st;
    e.halted = h;
    e.wdt    = m_wdt;
    e.cnt    = CW'(m_count);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    bus_if.run       = 1'($urandom);
    bus_if.hlt       = 1'($urandom);
    bus_if.exec_done = 1'($urandom);
    bus_if.exec_ctrl = 20'($urandom);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    m_count = 0;
    m_wdt   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_in();
      expect_cyc(20'h0, 1'b0, 1'b0);
      step();
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_in();
      bus_if.run = 1'b0;
      expect_cyc(20'h0, 1'b0, 1'b0);
      step();
    end
  endtask

  task automatic start_run();
    rand_in();
    bus_if.run = 1'b1;
    expect_cyc(20'h0, 1'b0, 1'b0);
    step();
  endtask

  task automatic halt_cycles();
    for (int i = 0; i < 10; i++) begin
      rand_in();
      bus_if.run = 1'(i);
      expect_cyc(20'h0, 1'b0, 1'b1);
      step();
    end
  endtask

  // Reset raised mid-cycle; outputs must clear before any clock edge.
  task automatic async_abort();
    m_count = 0;
    m_wdt   = 1'b0;
    expect_cyc(20'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async control_bus", 32'(bus_if.control_bus), 32'h0);
    chk("async exec_start",  32'(bus_if.exec_start),  32'h0);
    chk("async halted",      32'(bus_if.halted),      32'h0);
    chk("async wdt_err",     32'(bus_if.wdt_err),     32'h0);
    chk("async instr_count", 32'(bus_if.instr_count), 32'h0);
    @(posedge clk);
    #1;
    rand_in();
    expect_cyc(20'h0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  // One instruction: n = EXEC cycle carrying exec_done (0 = never),
  // abort: 1 = reset during F3, 2 = reset in the second EXEC cycle.
  task automatic do_instr(input bit hlt, input int n, input int abort, input bit fixc);
    for (int i = 0; i < 5; i++) begin
      rand_in();
      if (fixc) bus_if.exec_ctrl = 20'hABCDE;
      if (i == 4) bus_if.hlt = hlt;
      if (abort == 1 && i == 3) begin
        async_abort();
        return;
      end
      expect_cyc(fetch_w[i], 1'b0, 1'b0);
      step();
    end
    if (hlt) begin
      halt_cycles();
      return;
    end
    for (int k = 1; k <= TO; k++) begin
      rand_in();
      if (fixc) bus_if.exec_ctrl = 20'hABCDE;
      bus_if.exec_done = (k == n);
      if (abort == 2 && k == 2) begin
        async_abort();
        return;
      end
      expect_cyc(bus_if.exec_ctrl, (k == 1), 1'b0);
      step();
      if (k == n) begin
        m_count++;
        return;
      end
    end
    m_wdt = 1'b1;
    halt_cycles();
  endtask

  initial begin
    bus_if.run       = 1'b0;
    bus_if.hlt       = 1'b0;
    bus_if.exec_done = 1'b0;
    bus_if.exec_ctrl = '0;
    @(posedge clk);
    #1;
    do_reset();
    start_run();
    repeat (3) do_instr(1'b0, 1, 0, 1'b0);
    do_instr(1'b0, TO, 0, 1'b1);
    repeat (6) do_instr(1'b0, $urandom_range(1, TO), 0, 1'b0);
    do_instr(1'b0, 0, 1, 1'b0);
    start_run();
    do_instr(1'b0, 3, 0, 1'b0);
    do_instr(1'b0, 0, 2, 1'b1);
    start_run();
    repeat (18) do_instr(1'b0, $urandom_range(1, TO), 0, 1'($urandom_range(0, 1)));
    do_instr(1'b1, 1, 0, 1'b0);
    do_reset();
    start_run();
    do_instr(1'b0, 2, 0, 1'b0);
    do_instr(1'b0, 0, 0, 1'b0);
    do_reset();
    start_run();
    do_instr(1'b0, 1, 0, 1'b0);
    @(negedge clk);
    #1;
    chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control-bus master for the CPU: generates the 5-state instruction fetch sequence (memory -> IR0, memory -> IR1, PC increments), then hands the bus to the execute unit until it reports completion.
- Drives the packed control bus consumed by the CPU datapath (bus arbitration IDs, PC increment, ALU opcode).
- Stops on HLT.
- Flags an error when an execute phase exceeds a cycle budget.

Parameters:
- CTRL_W, 20, control bus width; packing is {ALU_OPCODE[4:0], MID[4:0], SID[4:0], AMID[1:0], PC_INR, MID_EN, SID_EN}, MSB first.
- EXEC_TIMEOUT, 64, maximum EXEC cycles before a watchdog error; legal range 2..65535.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- run  in  1  level; leaves IDLE when high.
- hlt  in  1  decoded "IR0 holds HLT", from the decoder; sampled only in F4.
- exec_ctrl  in  CTRL_W  control word from the execute unit; forwarded in EXEC only.
- exec_done  in  1  execute unit finished; sampled only in EXEC.
- control_bus  out  CTRL_W  packed control bus to the datapath.
- exec_start  out  1  one-cycle pulse in the first EXEC cycle.
- halted  out  1  high in HALT.
- wdt_err  out  1  sticky; set on execute timeout.
- instr_count  out  CNT_W  count of completed EXEC phases; wraps.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, control_bus=0, exec_start=0, halted=0, wdt_err=0, instr_count=0, watchdog counter=0.
  - An all-zero bus is inert: all enables are 0.
  - Reset asserted mid-fetch or mid-EXEC aborts immediately; there is no partial completion.
- States: IDLE, F0, F1, F2, F3, F4, EXEC, HALT. The state is registered; control_bus is a Moore decode of the state, except in EXEC.
- Constants: MID_MEM=4, SID_IR0=0, SID_IR1=1, AMID_PC=0.
- Fetch-state outputs (fields not listed are 0):
  - F0: AMID=PC, MID=MEM, MID_EN=1.
  - F1: AMID=PC, MID=MEM, MID_EN=1, SID=IR0, SID_EN=1, PC_INR=1.
  - F2: AMID=PC, MID=MEM, MID_EN=1, SID=IR0, SID_EN=0, PC_INR=0.
  - F3: AMID=PC, MID=MEM, MID_EN=1, SID=IR1, SID_EN=1, PC_INR=1.
  - F4: all enables 0, PC_INR=0.
- Transitions:
  - IDLE -> F0 when run=1, else stay.
  - F0 -> F1 -> F2 -> F3 -> F4, unconditionally.
  - F4 -> HALT if hlt=1; else F4 -> EXEC.
  - EXEC -> F0 on exec_done=1, and instr_count increments by 1 in that same cycle.
  - EXEC -> HALT on watchdog expiry, and wdt_err sets.
  - HALT -> HALT until reset; run has no effect.
- run is checked only in IDLE. Deasserting run mid-program does not stop the fetch/execute loop.
- EXEC:
  - control_bus = exec_ctrl, combinational pass-through.
  - exec_start=1 only in the first EXEC cycle.
  - exec_done asserted in that first cycle is honoured, giving a minimum EXEC length of 1 cycle.
- Watchdog:
  - Counter clears on EXEC entry and increments each EXEC cycle without exec_done.
  - When the count reaches EXEC_TIMEOUT-1 with no exec_done, the next edge goes to HALT.
  - exec_done in that same cycle wins: no error.
- Throughput: 5 fetch cycles plus N EXEC cycles per instruction. The first F0 comes 1 cycle after run is sampled high in IDLE.
- instr_count wraps from 2^CNT_W-1 to 0 silently.
- HLT does not increment instr_count.
- halted=1 exactly when state=HALT.
- wdt_err stays set until reset.

Decomposition:
- Shared package/include holds:
  - control bus field positions and widths;
  - state encodings;
  - MID_MEM, SID_IR0, SID_IR1 and AMID_PC constants;
  - a control-word pack macro.
- One sub-module, exec_watchdog: counter, clear-on-entry, expiry flag, parameter EXEC_TIMEOUT.

Test Plan:
1. Reset, run=1, hlt=0, exec_done=1 whenever exec_start=1 -> bus matches the F0..F4 table cycle by cycle. After the first EXEC cycle the bus returns to F0. instr_count=1 after the first instruction and 3 after three loops; the period is 6 cycles.
2. hlt=1 at the first F4 -> state goes to HALT, halted=1, control_bus=0, instr_count stays 0. Toggling run for 10 cycles changes nothing.
3. EXEC_TIMEOUT=8, exec_done held 0 -> HALT and wdt_err=1 after exactly 8 EXEC cycles. A variant with exec_done=1 on the 8th cycle -> back to F0, wdt_err=0.
4. exec_ctrl=20'hABCDE during EXEC -> control_bus=20'hABCDE in every EXEC cycle and never during F0..F4.
5. Assert reset asynchronously (between clock edges) during F3 and during EXEC -> all outputs are 0 immediately, without waiting for a clock edge. After release, with run=1, the sequence restarts at F0.
6. CNT_W=4, 17 instructions -> instr_count wraps 15 -> 0 and reads 1.
